axis_matvec_coproc: RTL and testbench

AXIS_MATVEC_COPROC -- requirements
Module: axis_matvec_coproc

---
 rtl/axis_matvec_coproc.sv | 173 +++++++++++++++++
 tb/tb_axis_matvec_coproc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_matvec_coproc.sv
// axis_matvec_coproc: streams in matrix A then vector B, computes
// RES = min((A*B) >> RES_SHIFT, max) one MAC per cycle, streams RES out.
module axis_matvec_coproc #(
  parameter int ROWS      = 64,
  parameter int COLS      = 8,
  parameter int DATA_W    = 8,
  parameter int RES_SHIFT = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        FRAME_ERR
);
  localparam int CB    = $clog2(COLS);
  localparam int AW    = $clog2(ROWS * COLS);
  localparam int RW    = AW - CB;
  localparam int ACC_W = 2 * DATA_W + CB;
  localparam logic [AW-1:0] LAST_A = AW'(ROWS * COLS - 1);
  localparam logic [CB-1:0] LAST_C = CB'(COLS - 1);
  localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
  localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {
    READ_A, READ_B, COMPUTE, WRITE
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] out_q, out_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic s_rdy_q, s_rdy_d;
  logic m_vld_q, m_vld_d;
  logic m_last_q, m_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic err_q, err_d;

  logic [DATA_W-1:0] a_mem [ROWS*COLS];
  logic [DATA_W-1:0] b_mem [COLS];
  logic [DATA_W-1:0] res_mem [ROWS];

  logic s_xfer;
  logic [CB-1:0] col;
  logic [RW-1:0] row;
  logic [RW-1:0] out_nx;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shifted;
  logic [DATA_W-1:0] res_val;
  logic unused_tdata;

  assign unused_tdata = ^S_AXIS_TDATA[31:DATA_W];
  assign s_xfer  = S_AXIS_TVALID & s_rdy_q;
  assign col     = cnt_q[CB-1:0];
  assign row     = cnt_q[AW-1:CB];
  assign out_nx  = out_q + 1'b1;
  assign prod    = ACC_W'(a_mem[cnt_q]) * ACC_W'(b_mem[col]);
  assign sum     = acc_q + prod;
  assign shifted = sum >> RES_SHIFT;
  assign res_val = (shifted > MAXV) ? MAXV[DATA_W-1:0]
                                    : shifted[DATA_W-1:0];

  // Next-state logic for the frame sequencer, MAC and output stream.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    acc_d    = acc_q;
    m_vld_d  = m_vld_q;
    m_last_d = m_last_q;
    m_data_d = m_data_q;
    err_d    = err_q;
    unique case (state_q)
      READ_A: if (s_xfer) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) err_d = S_AXIS_TLAST;
        else err_d = err_q | S_AXIS_TLAST;
        if (cnt_q == LAST_A) begin
          state_d = READ_B;
          cnt_d   = '0;
        end
      end
      READ_B: if (s_xfer) begin
        cnt_d = cnt_q + 1'b1;
        if (col == LAST_C) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          err_d   = err_q | ~S_AXIS_TLAST;
        end else begin
          err_d = err_q | S_AXIS_TLAST;
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = (col == LAST_C) ? '0 : sum;
        if (cnt_q == LAST_A) begin
          state_d = WRITE;
          cnt_d   = '0;
          out_d   = '0;
        end
      end
      WRITE: begin
        if (!m_vld_q) begin
          m_vld_d  = 1'b1;
          m_data_d = res_mem[out_q];
          m_last_d = (out_q == LAST_R);
        end else if (M_AXIS_TREADY) begin
          if (m_last_q) begin
            m_vld_d  = 1'b0;
            m_last_d = 1'b0;
            m_data_d = '0;
            out_d    = '0;
            state_d  = READ_A;
          end else begin
            out_d    = out_nx;
            m_data_d = res_mem[out_nx];
            m_last_d = (out_nx == LAST_R);
          end
        end
      end
      default: state_d = READ_A;
    endcase
    s_rdy_d = (state_d == READ_A) || (state_d == READ_B);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= READ_A;
      cnt_q    <= '0;
      out_q    <= '0;
      acc_q    <= '0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      acc_q    <= acc_d;
      s_rdy_q  <= s_rdy_d;
      m_vld_q  <= m_vld_d;
      m_last_q <= m_last_d;
      m_data_q <= m_data_d;
      err_q    <= err_d;
    end
  end

  // Operand and result storage; contents need no reset.
  always_ff @(posedge ACLK) begin
    if (s_xfer && state_q == READ_A)
      a_mem[cnt_q] <= S_AXIS_TDATA[DATA_W-1:0];
    if (s_xfer && state_q == READ_B)
      b_mem[col] <= S_AXIS_TDATA[DATA_W-1:0];
    if (state_q == COMPUTE && col == LAST_C)
      res_mem[row] <= res_val;
  end

  assign S_AXIS_TREADY = s_rdy_q;
  assign M_AXIS_TVALID = m_vld_q;
  assign M_AXIS_TDATA  = 32'(m_data_q);
  assign M_AXIS_TLAST  = m_last_q;
  assign FRAME_ERR     = err_q;

endmodule

// File: tb/tb_axis_matvec_coproc.sv
// tb_axis_matvec_coproc: directed bench for a default-size and a
// 4x2 coprocessor sharing one stream driver selected by sel.
module tb_axis_matvec_coproc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic s_tlast = 1'b0;
  logic m_tready = 1'b0;

  logic d_srdy, d_mvld, d_mlast, d_err;
  logic [31:0] d_mdata;
  logic q_srdy, q_mvld, q_mlast, q_err;
  logic [31:0] q_mdata;

  logic s_tready, m_tvalid, m_tlast, f_err;
  logic [31:0] m_tdata;
  assign s_tready = sel ? q_srdy : d_srdy;
  assign m_tvalid = sel ? q_mvld : d_mvld;
  assign m_tlast  = sel ? q_mlast : d_mlast;
  assign m_tdata  = sel ? q_mdata : d_mdata;
  assign f_err    = sel ? q_err : d_err;

  int tests = 0;
  int fails = 0;
  int av[$];
  int bv[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  axis_matvec_coproc u_def (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TREADY(d_srdy), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid & ~sel),
    .M_AXIS_TVALID(d_mvld), .M_AXIS_TDATA(d_mdata),
    .M_AXIS_TLAST(d_mlast), .M_AXIS_TREADY(m_tready & ~sel),
    .FRAME_ERR(d_err)
  );

  axis_matvec_coproc #(
    .ROWS(4), .COLS(2), .DATA_W(8), .RES_SHIFT(0)
  ) u_sm (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TREADY(q_srdy), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid & sel),
    .M_AXIS_TVALID(q_mvld), .M_AXIS_TDATA(q_mdata),
    .M_AXIS_TLAST(q_mlast), .M_AXIS_TREADY(m_tready & sel),
    .FRAME_ERR(q_err)
  );

  task automatic set_vec(input int which);
    av.delete();
    bv.delete();
    for (int k = 0; k < 512; k++) begin
      if (which == 1) av.push_back((k * 7 + 3) & 63);
      else if (which == 2) av.push_back((k * 11 + 9) & 127);
      else av.push_back(255);
    end
    for (int c = 0; c < 8; c++) begin
      if (which == 1) bv.push_back((c * 5 + 1) & 31);
      else if (which == 2) bv.push_back((c * 9 + 20) & 63);
      else bv.push_back(255);
    end
  endtask

  task automatic gold(input int rows, input int cols, input int sh);
    longint acc;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      acc = 0;
      for (int c = 0; c < cols; c++)
        acc += longint'(av[r * cols + c]) * longint'(bv[c]);
      acc = acc >> sh;
      if (acc > 255) acc = 255;
      exp_q.push_back(32'(acc));
    end
  endtask

  task automatic put_word(input logic [31:0] w, input logic last);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata = w;
    s_tlast = last;
    while (s_tready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL put_word timeout tready=%b want 1", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_range(input int k0, input int k1,
                            input int g1, input int g2, input int bad);
    int n;
    logic [31:0] w;
    n = av.size() + bv.size();
    for (int k = k0; k < k1; k++) begin
      if (k < av.size()) w = 32'(av[k]);
      else w = 32'(bv[k - av.size()]);
      put_word(w, (k == n - 1) || (k == bad));
      if (k == g1) repeat (1) begin @(posedge clk); #1; end
      if (k == g2) repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_frame(input int g1, input int g2, input int bad);
    send_range(0, av.size() + bv.size(), g1, g2, bad);
  endtask

  task automatic collect(input int rows, input int stall_at,
                         input string nm);
    int n;
    logic [31:0] hd;
    m_tready = 1'b1;
    for (int i = 0; i < rows; i++) begin
      n = 0;
      while (m_tvalid !== 1'b1 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 3000) begin
        tests++;
        fails++;
        $display("FAIL %s w%0d timeout tvalid=%b want 1",
                 nm, i, m_tvalid);
        return;
      end
      if (i == stall_at) begin
        m_tready = 1'b0;
        hd = m_tdata;
        @(posedge clk); #1;
        tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== hd) begin
          fails++;
          $display("FAIL %s stall got vld=%b d=%h want 1 %h",
                   nm, m_tvalid, m_tdata, hd);
        end
        m_tready = 1'b1;
      end
      tests++;
      if (m_tdata !== exp_q[i] || m_tlast !== (i == rows - 1)) begin
        fails++;
        $display("FAIL %s w%0d got d=%h last=%b want d=%h last=%b",
                 nm, i, m_tdata, m_tlast, exp_q[i], (i == rows - 1));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s end tvalid=%b want 0", nm, m_tvalid);
    end
  endtask

  task automatic chk_zero(input string nm);
    tests++;
    if ({d_srdy, d_mvld, d_mlast, d_err} !== 4'b0 || d_mdata !== '0 ||
        {q_srdy, q_mvld, q_mlast, q_err} !== 4'b0 || q_mdata !== '0) begin
      fails++;
      $display("FAIL %s got d=%b%b%b%b/%h q=%b%b%b%b/%h want all 0", nm,
               d_srdy, d_mvld, d_mlast, d_err, d_mdata,
               q_srdy, q_mvld, q_mlast, q_err, q_mdata);
    end
  endtask

  task automatic test_reset();
    #12;
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (d_srdy !== 1'b1 || q_srdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_release tready got %b %b want 1 1",
               d_srdy, q_srdy);
    end
  endtask

  task automatic test_small_basic();
    sel = 1'b1;
    av.delete();
    bv.delete();
    for (int k = 0; k < 8; k++) av.push_back(1);
    bv.push_back(2);
    bv.push_back(3);
    exp_q = '{32'h5, 32'h5, 32'h5, 32'h5};
    send_frame(-1, -1, -1);
    collect(4, -1, "small_basic");
    tests++;
    if (f_err !== 1'b0) begin
      fails++;
      $display("FAIL small_ferr got %b want 0", f_err);
    end
  endtask

  task automatic test_small_saturate();
    sel = 1'b1;
    av.delete();
    bv.delete();
    for (int k = 0; k < 8; k++) av.push_back(255);
    bv.push_back(255);
    bv.push_back(255);
    exp_q = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};
    send_frame(-1, -1, -1);
    collect(4, -1, "small_sat");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    set_vec(1);
    gold(64, 8, 8);
    send_frame(-1, -1, -1);
    collect(64, -1, "b2b_f1");
    tests++;
    if (s_tready !== 1'b1 || f_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap got tready=%b ferr=%b want 1 0",
               s_tready, f_err);
    end
    set_vec(2);
    gold(64, 8, 8);
    send_frame(-1, -1, -1);
    collect(64, -1, "b2b_f2");
    tests++;
    if (f_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ferr got %b want 0", f_err);
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    set_vec(1);
    gold(64, 8, 8);
    send_frame(5, 10, -1);
    collect(64, 2, "stall");
  endtask

  task automatic test_saturate_default();
    sel = 1'b0;
    set_vec(3);
    exp_q.delete();
    for (int r = 0; r < 64; r++) exp_q.push_back(32'hFF);
    send_frame(-1, -1, -1);
    collect(64, -1, "def_sat");
  endtask

  task automatic test_frame_err();
    sel = 1'b0;
    set_vec(2);
    gold(64, 8, 8);
    send_range(0, 3, -1, -1, 3);
    tests++;
    if (f_err !== 1'b0) begin
      fails++;
      $display("FAIL ferr_early got %b want 0", f_err);
    end
    send_range(3, 520, -1, -1, 3);
    tests++;
    if (f_err !== 1'b1) begin
      fails++;
      $display("FAIL ferr_set got %b want 1", f_err);
    end
    collect(64, -1, "ferr_frame");
    tests++;
    if (f_err !== 1'b1) begin
      fails++;
      $display("FAIL ferr_sticky got %b want 1", f_err);
    end
    set_vec(1);
    gold(64, 8, 8);
    send_range(0, 1, -1, -1, -1);
    tests++;
    if (f_err !== 1'b0) begin
      fails++;
      $display("FAIL ferr_clear got %b want 0", f_err);
    end
    send_range(1, 520, -1, -1, -1);
    collect(64, -1, "ferr_next");
  endtask

  task automatic test_reset_compute();
    sel = 1'b0;
    set_vec(2);
    send_frame(-1, -1, -1);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_zero("rst_compute");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (d_srdy !== 1'b1 || d_mvld !== 1'b0) begin
      fails++;
      $display("FAIL rst_release got tready=%b tvalid=%b want 1 0",
               d_srdy, d_mvld);
    end
    set_vec(1);
    gold(64, 8, 8);
    send_frame(-1, -1, -1);
    collect(64, -1, "rst_fresh");
  endtask

  initial begin
    test_reset();
    test_small_basic();
    test_small_saturate();
    test_back_to_back();
    test_stall();
    test_saturate_default();
    test_frame_err();
    test_reset_compute();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
